// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// FETCH_ADDR_W sets the PC width carried in queue entries; fetch_unit's ADDR_W must match it.
package fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int FETCH_ADDR_W = 20;

    // Canonical no-op, used to pre-fill queue storage so debug dumps read as harmless code.
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]      data;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue of {pc, data}; push lands in one cycle, head is combinational.
// No internal backpressure: the producer's credit check guarantees no push while full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    resetn,
    input  logic                    push_i,
    input  fq_entry_t               push_data_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output fq_entry_t               head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o,
    output logic                    full_o
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

    fq_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    // Empty head reads as all-zero so decode never sees a stale pc/data pair.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !do_pop)      count_q <= count_q + 1'b1;
            else if (!push_i && do_pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: '0, data: NOP};
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues one outstanding cache read, queues words for decode.
// Hits stream one word/cycle; misses/redirects stall issue. FETCH_PERF_CNT_EN adds a miss-stall counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = FETCH_ADDR_W,
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                CLK,
    input  logic                resetn,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                ic_read_en,
    output logic [ADDR_W-1:0]   ic_read_addr,
    input  logic                ic_cache_miss,
    input  logic                ic_fetch_valid,
    input  logic [INSTR_W-1:0]  ic_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr_data,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic [31:0]         perf_miss_cycles
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               outstanding_q, outstanding_d;
    logic               drop_q, drop_d;

    logic               credit_ok, issue, rsp, push, pop;
    logic [CW-1:0]      q_count;
    logic               q_empty, q_full;
    fq_entry_t          q_head, q_push_data;
    logic               unused_sigs;

    // In-flight request counts against queue space so a returning word always has a slot.
    assign credit_ok   = (int'(q_count) + int'(outstanding_q)) < QUEUE_DEPTH;
    assign issue       = (state_q == RUN) && !drop_q && credit_ok && !ic_cache_miss && !redirect_valid;
    assign rsp         = ic_fetch_valid && outstanding_q;
    assign push        = rsp && !drop_q && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign q_push_data = '{pc: req_pc_q, data: ic_rdata};
    assign unused_sigs = &{1'b0, redirect_pc[1:0], q_full};

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state_q <= BOOT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (outstanding_q && ic_cache_miss && !ic_fetch_valid) state_d = MISS;
            MISS:    if (ic_fetch_valid) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // While a dropped request is pending the cache keeps seeing its old address, so a refill completes.
    always_comb begin
        ic_read_en   = 1'b0;
        ic_read_addr = pc_q;
        case (state_q)
            RUN:     ic_read_en = drop_q || credit_ok;
            MISS:    ic_read_en = 1'b1;
            default: ic_read_en = 1'b0;
        endcase
        if (state_q == MISS || drop_q) ic_read_addr = req_pc_q;
    end

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (rsp) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end
        if (issue) begin
            pc_d          = pc_q + ADDR_W'(4);
            req_pc_d      = pc_q;
            outstanding_d = 1'b1;
        end
        if (redirect_valid) begin
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            if (outstanding_q && !ic_fetch_valid) drop_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .CLK         (CLK),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i (q_push_data),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (q_head),
        .count_o     (q_count),
        .empty_o     (q_empty),
        .full_o      (q_full)
    );

    assign instr_valid = !q_empty;
    assign instr_data  = q_head.data;
    assign instr_pc    = q_head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            perf_q <= '0;
        end else if ((state_q == MISS || drop_q) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_miss_cycles = perf_q;
`else
    assign perf_miss_cycles = '0;
`endif

endmodule
